// File: rtl/imm_literal_parser_pkg.sv
// Shared assembler constants: parser state type, error codes and ASCII helpers.
// The BIN states exist only when IMM_PARSER_BIN_EN is defined.
package imm_literal_parser_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SIGN,
    ST_ZERO,
    ST_HEX_FIRST,
    ST_HEX,
`ifdef IMM_PARSER_BIN_EN
    ST_BIN_FIRST,
    ST_BIN,
`endif
    ST_DEC,
    ST_RETURN,
    ST_ERROR
  } state_t;

  typedef enum logic {
    RADIX_DEC,
    RADIX_POW2
  } radix_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_RANGE    = 2'd3;

  function automatic logic is_num(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic logic is_hex_digit(input logic [7:0] c);
    return is_num(c) || ((c >= "a") && (c <= "f")) || ((c >= "A") && (c <= "F"));
  endfunction

  function automatic logic is_delimiter(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h2C) || (c == 8'h28) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic logic [3:0] ascii_to_hex(input logic [7:0] c);
    logic [7:0] t;
    t = 8'h00;
    if (is_num(c))                      t = c - 8'h30;
    else if ((c >= "a") && (c <= "f"))  t = c - 8'h57;
    else if ((c >= "A") && (c <= "F"))  t = c - 8'h37;
    return t[3:0];
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational range check and sign/zero extension of a parsed literal
// against the runtime field width.
module imm_range_check
  import imm_literal_parser_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RB_W  = 6
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             neg,
  input  radix_t           radix,
  input  logic [RB_W-1:0]  range_bits,
  input  logic             is_unsigned,
  output logic [WIDTH-1:0] value,
  output logic             in_range
);

  logic [RB_W-1:0]  rb;
  logic [WIDTH:0]   limit;
  logic [WIDTH:0]   half;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] negated;
  logic             sign;

  always_comb begin
    // Field widths beyond WIDTH behave like WIDTH so 2^rb never wraps.
    rb      = (int'(range_bits) > WIDTH) ? RB_W'(WIDTH) : range_bits;
    limit   = (WIDTH + 1)'(1) << rb;
    half    = limit >> 1;
    mask    = limit[WIDTH-1:0] - WIDTH'(1);
    negated = WIDTH'(0) - acc;
    sign    = |(acc & half[WIDTH-1:0]);
    value    = acc;
    in_range = 1'b0;
    if (radix == RADIX_POW2) begin
      in_range = {1'b0, acc} < limit;
      value    = (!is_unsigned && sign) ? (acc | ~mask) : acc;
    end else if (is_unsigned) begin
      in_range = !(neg && (acc != '0)) && ({1'b0, acc} < limit);
      value    = neg ? negated : acc;
    end else begin
      in_range = neg ? ({1'b0, acc} <= half) : ({1'b0, acc} < half);
      value    = neg ? negated : acc;
    end
  end

endmodule

// File: rtl/imm_literal_parser.sv
// Streaming ASCII numeric-literal parser (decimal, 0x hex, optional 0b binary
// when IMM_PARSER_BIN_EN is defined) producing a range-checked WIDTH-bit immediate.
module imm_literal_parser
  import imm_literal_parser_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RB_W  = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_data,
  input  logic             new_character,
  input  logic [7:0]       incoming_ascii,
  input  logic             is_unsigned,
  input  logic [RB_W-1:0]  range_bits,
  output logic [WIDTH-1:0] immediate,
  output logic             done_flag,
  output logic             error_flag,
  output logic [1:0]       error_code,
  output logic             busy_flag
);

  // Handshake: a character is consumed on a rising edge where valid_data and
  // new_character are both high; valid_data low aborts to IDLE from any state.
  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n, imm_n, ext_value;
  logic             neg, neg_n, in_range, legal, overflow, finalize, fail;
  logic [1:0]       code_n, fail_code;
  logic [3:0]       digit;
  logic [WIDTH+3:0] acc_ext, acc_wide, hex_next, dec_next;
  radix_t           radix;

  assign digit    = ascii_to_hex(incoming_ascii);
  assign acc_ext  = {4'b0000, acc};
  assign hex_next = (acc_ext << 4) | {{WIDTH{1'b0}}, digit};
  assign dec_next = (acc_ext << 3) + (acc_ext << 1) + (WIDTH + 4)'(digit);
  assign overflow = |acc_wide[WIDTH+3:WIDTH];
  assign radix    = ((state == ST_DEC) || (state == ST_ZERO)) ? RADIX_DEC : RADIX_POW2;

`ifdef IMM_PARSER_BIN_EN
  logic [WIDTH+3:0] bin_next;
  assign bin_next = (acc_ext << 1) | (WIDTH + 4)'(digit[0]);
`endif

  imm_range_check #(.WIDTH(WIDTH), .RB_W(RB_W)) u_range_check (
    .acc         (acc),
    .neg         (neg),
    .radix       (radix),
    .range_bits  (range_bits),
    .is_unsigned (is_unsigned),
    .value       (ext_value),
    .in_range    (in_range)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      acc        <= '0;
      neg        <= 1'b0;
      immediate  <= '0;
      error_code <= ERR_NONE;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      neg        <= neg_n;
      immediate  <= imm_n;
      error_code <= code_n;
    end
  end

  always_comb begin
    legal    = 1'b0;
    acc_wide = dec_next;
    case (state)
      ST_HEX_FIRST, ST_HEX: begin
        legal    = is_hex_digit(incoming_ascii);
        acc_wide = hex_next;
      end
`ifdef IMM_PARSER_BIN_EN
      ST_BIN_FIRST, ST_BIN: begin
        legal    = (incoming_ascii == "0") || (incoming_ascii == "1");
        acc_wide = bin_next;
      end
`endif
      ST_DEC:  legal = is_num(incoming_ascii);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    neg_n     = neg;
    imm_n     = immediate;
    code_n    = error_code;
    finalize  = 1'b0;
    fail      = 1'b0;
    fail_code = ERR_BAD_CHAR;
    if (!valid_data) begin
      state_n = ST_IDLE;
      code_n  = ERR_NONE;
      acc_n   = '0;
      neg_n   = 1'b0;
    end else if (state == ST_RETURN) begin
      state_n = ST_IDLE;
    end else if (new_character) begin
      case (state)
        ST_IDLE: begin
          if (incoming_ascii == "-") begin
            state_n = ST_SIGN;
            neg_n   = 1'b1;
            acc_n   = '0;
          end else if (incoming_ascii == "0") begin
            state_n = ST_ZERO;
            neg_n   = 1'b0;
            acc_n   = '0;
          end else if (is_num(incoming_ascii)) begin
            state_n = ST_DEC;
            neg_n   = 1'b0;
            acc_n   = WIDTH'(digit);
          end
        end
        ST_SIGN: begin
          if (is_num(incoming_ascii)) begin
            state_n = ST_DEC;
            acc_n   = WIDTH'(digit);
          end else fail = 1'b1;
        end
        ST_ZERO: begin
          if ((incoming_ascii == "x") || (incoming_ascii == "X")) state_n = ST_HEX_FIRST;
`ifdef IMM_PARSER_BIN_EN
          else if ((incoming_ascii == "b") || (incoming_ascii == "B")) state_n = ST_BIN_FIRST;
`endif
          else if (is_num(incoming_ascii)) begin
            state_n = ST_DEC;
            acc_n   = WIDTH'(digit);
          end else if (is_delimiter(incoming_ascii)) finalize = 1'b1;
          else fail = 1'b1;
        end
        ST_HEX_FIRST: begin
          if (legal) begin
            state_n = ST_HEX;
            acc_n   = acc_wide[WIDTH-1:0];
          end else fail = 1'b1;
        end
`ifdef IMM_PARSER_BIN_EN
        ST_BIN_FIRST: begin
          if (legal) begin
            state_n = ST_BIN;
            acc_n   = acc_wide[WIDTH-1:0];
          end else fail = 1'b1;
        end
        ST_BIN,
`endif
        ST_HEX, ST_DEC: begin
          if (is_delimiter(incoming_ascii)) finalize = 1'b1;
          else if (!legal) fail = 1'b1;
          else if (overflow) begin
            fail      = 1'b1;
            fail_code = ERR_OVERFLOW;
          end else acc_n = acc_wide[WIDTH-1:0];
        end
        default: ;
      endcase
      if (fail) begin
        state_n = ST_ERROR;
        code_n  = fail_code;
      end
      if (finalize) begin
        if (in_range) begin
          imm_n   = ext_value;
          state_n = ST_RETURN;
        end else begin
          state_n = ST_ERROR;
          code_n  = ERR_RANGE;
        end
      end
    end
  end

  assign done_flag  = (state == ST_RETURN);
  assign error_flag = (state == ST_ERROR);
  assign busy_flag  = (state != ST_IDLE);

endmodule
